// File: rtl/fmt_int_ascii.sv
// Integer-to-ASCII formatter: renders a 32-bit value as a right-aligned string register
// using %d/%h/%o/%b rules with default, minimal or explicit field width.
module fmt_int_ascii #(
  parameter int LENGTH = 34
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [31:0]         value,
  input  logic [1:0]          radix,
  input  logic                is_signed,
  input  logic                plus_flag,
  input  logic [1:0]          width_sel,
  input  logic [5:0]          fmt_width,
  input  logic                left_just,
  output logic                busy,
  output logic                done,
  output logic [LENGTH*8-1:0] result
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DIGITS,
    S_SIGN,
    S_PAD,
    S_DONE
  } state_t;

  localparam logic [1:0] RADIX_DEC = 2'd0;
  localparam logic [1:0] RADIX_HEX = 2'd1;
  localparam logic [1:0] RADIX_OCT = 2'd2;

  localparam logic [1:0] WSEL_MINIMAL  = 2'd1;
  localparam logic [1:0] WSEL_EXPLICIT = 2'd2;

  state_t      state_q, state_d;

  logic [31:0] mag_q;
  logic [1:0]  radix_q;
  logic        signed_q;
  logic        plus_q;
  logic        left_q;
  logic        fixed_q;   // leading zeros kept: digit count fixed by radix
  logic [5:0]  ndig_q;
  logic [6:0]  tgt_q;     // field width to pad up to
  logic        neg_q;
  logic        sign_q;
  logic [5:0]  dcnt_q;
  logic [6:0]  cnt_q;     // characters emitted so far

  logic [3:0]  digit;
  logic [31:0] mag_next;
  logic [7:0]  digit_ch;
  logic        last_digit;
  logic        more_pad;
  logic        neg_c;
  logic        wr_en;
  logic [7:0]  wr_ch;

  function automatic logic [6:0] default_width(input logic [1:0] r, input logic s);
    case (r)
      RADIX_DEC: return s ? 7'd11 : 7'd10;
      RADIX_HEX: return 7'd8;
      RADIX_OCT: return 7'd11;
      default:   return 7'd32;
    endcase
  endfunction

  function automatic logic [5:0] fixed_digits(input logic [1:0] r);
    case (r)
      RADIX_HEX: return 6'd8;
      RADIX_OCT: return 6'd11;
      default:   return 6'd32;
    endcase
  endfunction

  // NOTE: every variable assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    digit    = '0;
    mag_next = mag_q;
    case (radix_q)
      RADIX_DEC: begin
        digit    = 4'(mag_q % 32'd10);
        mag_next = mag_q / 32'd10;
      end
      RADIX_HEX: begin
        digit    = mag_q[3:0];
        mag_next = mag_q >> 4;
      end
      RADIX_OCT: begin
        digit    = {1'b0, mag_q[2:0]};
        mag_next = mag_q >> 3;
      end
      default: begin
        digit    = {3'b000, mag_q[0]};
        mag_next = mag_q >> 1;
      end
    endcase
  end

  assign digit_ch   = (digit < 4'd10) ? (8'h30 + {4'h0, digit}) : (8'h57 + {4'h0, digit});
  assign last_digit = fixed_q ? (dcnt_q == ndig_q - 6'd1) : (mag_next == '0);
  assign more_pad   = (cnt_q + 7'd1) < tgt_q;
  assign neg_c      = signed_q && (radix_q == RADIX_DEC) && mag_q[31];

  // Characters written at byte cnt_q; left-justified padding shifts instead.
  always_comb begin
    wr_en = 1'b0;
    wr_ch = 8'h20;
    case (state_q)
      S_DIGITS: begin
        wr_en = 1'b1;
        wr_ch = digit_ch;
      end
      S_SIGN: begin
        wr_en = 1'b1;
        wr_ch = neg_q ? 8'h2d : 8'h2b;
      end
      S_PAD:   wr_en = !left_q;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_LOAD;
      S_LOAD:   state_d = S_DIGITS;
      S_DIGITS: begin
        if (last_digit) begin
          if (sign_q)        state_d = S_SIGN;
          else if (more_pad) state_d = S_PAD;
          else               state_d = S_DONE;
        end
      end
      S_SIGN:   state_d = more_pad ? S_PAD : S_DONE;
      S_PAD:    state_d = more_pad ? S_PAD : S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: the result register is reset like any other flop; it is a visible output, not storage RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result   <= '0;
      mag_q    <= '0;
      radix_q  <= '0;
      signed_q <= 1'b0;
      plus_q   <= 1'b0;
      left_q   <= 1'b0;
      fixed_q  <= 1'b0;
      ndig_q   <= '0;
      tgt_q    <= '0;
      neg_q    <= 1'b0;
      sign_q   <= 1'b0;
      dcnt_q   <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mag_q    <= value;
            radix_q  <= radix;
            signed_q <= is_signed;
            plus_q   <= plus_flag;
            left_q   <= left_just;
            fixed_q  <= (radix != RADIX_DEC) && (width_sel != WSEL_MINIMAL);
            ndig_q   <= fixed_digits(radix);
            case (width_sel)
              WSEL_MINIMAL:  tgt_q <= 7'd0;
              WSEL_EXPLICIT: tgt_q <= {1'b0, fmt_width};
              default:       tgt_q <= default_width(radix, is_signed);
            endcase
          end
        end
        S_LOAD: begin
          result <= '0;
          mag_q  <= neg_c ? (~mag_q + 32'd1) : mag_q;
          neg_q  <= neg_c;
          sign_q <= (radix_q == RADIX_DEC) && (neg_c || plus_q);
          cnt_q  <= '0;
          dcnt_q <= '0;
        end
        S_DIGITS: begin
          mag_q  <= mag_next;
          dcnt_q <= dcnt_q + 6'd1;
          cnt_q  <= cnt_q + 7'd1;
        end
        S_SIGN: cnt_q <= cnt_q + 7'd1;
        S_PAD: begin
          cnt_q <= cnt_q + 7'd1;
          if (left_q) result <= {result[LENGTH*8-9:0], 8'h20};
        end
        default: ;
      endcase

      // Bytes beyond LENGTH are dropped, matching truncating assignment to a string reg.
      for (int i = 0; i < LENGTH; i++) begin
        if (wr_en && (cnt_q == 7'(i))) result[i*8 +: 8] <= wr_ch;
      end
    end
  end

  assign busy = (state_q == S_LOAD) || (state_q == S_DIGITS) ||
                (state_q == S_SIGN) || (state_q == S_PAD);
  assign done = (state_q == S_DONE);

endmodule
